// File: rtl/fpu_mul_pipe.sv
// Three-stage IEEE-754 multiplier: unpack/multiply, normalise/round-nearest-even,
// special-case/pack. Subnormal inputs are treated as zero, and tiny results are flushed to zero.
module fpu_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [EXP_W+MAN_W:0]     i_float_A,
  input  logic [EXP_W+MAN_W:0]     i_float_B,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [EXP_W+MAN_W:0]     o_float_S,
  output logic                     o_overflow,
  output logic                     o_underflow,
  output logic                     o_inexact,
  output logic                     o_zero,
  output logic                     o_NaN
);
  localparam int FW = EXP_W + MAN_W + 1;
  localparam int PW = 2*MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W-1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic          sign;
    logic          nan;
    logic          inf;
    logic          zero;
    logic [EW-1:0] e;     // two's complement, wide enough for eA+eB-bias+2
  } cls_t;

  logic [3:1] vld_q;
  logic       en1, en2, en3;

  // A stage may load when it is empty or its content moves on this cycle.
  assign en3     = ~vld_q[3] | i_ready;
  assign en2     = ~vld_q[2] | en3;
  assign en1     = ~vld_q[1] | en2;
  assign o_ready = en1;
  assign o_valid = vld_q[3];

  // S1: classify and multiply significands
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;
  logic             a_z, a_i, a_n, b_z, b_i, b_n;
  cls_t             s1_d, s1_q;
  logic [PW-1:0]    p_d, p_q;

  assign a_e = i_float_A[MAN_W +: EXP_W];
  assign b_e = i_float_B[MAN_W +: EXP_W];
  assign a_m = i_float_A[MAN_W-1:0];
  assign b_m = i_float_B[MAN_W-1:0];
  assign a_z = (a_e == '0);
  assign b_z = (b_e == '0);
  assign a_i = (&a_e) & (a_m == '0);
  assign b_i = (&b_e) & (b_m == '0);
  assign a_n = (&a_e) & (|a_m);
  assign b_n = (&b_e) & (|b_m);

  always_comb begin
    s1_d.sign = i_float_A[FW-1] ^ i_float_B[FW-1];
    s1_d.nan  = a_n | b_n | (a_i & b_z) | (a_z & b_i);
    s1_d.inf  = a_i | b_i;
    s1_d.zero = a_z | b_z;
    s1_d.e    = EW'(a_e) + EW'(b_e) - BIAS;
    p_d       = PW'({1'b1, a_m}) * PW'({1'b1, b_m});
  end

  // S2: normalise so the leading one sits just above the kept fraction, then round
  logic [PW-2:0]    norm;
  logic [MAN_W-1:0] mant, mant_r, m_d, m_q;
  logic             g, st, rnd, cy, inx_d, inx_q;
  cls_t             s2_d, s2_q;

  always_comb begin
    norm   = p_q[PW-1] ? p_q[PW-2:0] : {p_q[PW-3:0], 1'b0};
    mant   = norm[PW-2 -: MAN_W];
    g      = norm[PW-2-MAN_W];
    st     = |norm[PW-3-MAN_W:0];
    rnd    = g & (st | mant[0]);
    {cy, mant_r} = {1'b0, mant} + (MAN_W+1)'(rnd);
    s2_d   = s1_q;
    s2_d.e = s1_q.e + EW'(p_q[PW-1]) + EW'(cy);
    m_d    = mant_r;
    inx_d  = g | st;
  end

  // S3: special operands first, then exponent range
  logic [FW-1:0] s_d;
  logic          ovf_d, unf_d, inx3_d, zero_d, nan_d;
  logic          e_neg, e_big, e_tiny;

  assign e_neg  = s2_q.e[EW-1];
  assign e_big  = ~e_neg & (s2_q.e >= EMAX);
  assign e_tiny = e_neg | (s2_q.e == '0);

  always_comb begin
    s_d    = {s2_q.sign, s2_q.e[EXP_W-1:0], m_q};
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inx3_d = inx_q;
    zero_d = 1'b0;
    nan_d  = 1'b0;
    if (s2_q.nan) begin
      s_d    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      nan_d  = 1'b1;
      inx3_d = 1'b0;
    end else if (s2_q.inf) begin
      s_d    = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      inx3_d = 1'b0;
    end else if (s2_q.zero) begin
      s_d    = {s2_q.sign, {(FW-1){1'b0}}};
      zero_d = 1'b1;
      inx3_d = 1'b0;
    end else if (e_big) begin
      s_d    = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d  = 1'b1;
      inx3_d = 1'b1;
    end else if (e_tiny) begin
      s_d    = {s2_q.sign, {(FW-1){1'b0}}};
      unf_d  = 1'b1;
      inx3_d = 1'b1;
      zero_d = 1'b1;
    end
  end

  // Payload registers load only with a valid op so bubbles never disturb held outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q       <= '0;
      s1_q        <= '0;
      p_q         <= '0;
      s2_q        <= '0;
      m_q         <= '0;
      inx_q       <= 1'b0;
      o_float_S   <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_inexact   <= 1'b0;
      o_zero      <= 1'b0;
      o_NaN       <= 1'b0;
    end else begin
      if (en1) vld_q[1] <= i_valid;
      if (en2) vld_q[2] <= vld_q[1];
      if (en3) vld_q[3] <= vld_q[2];
      if (en1 & i_valid) begin
        s1_q <= s1_d;
        p_q  <= p_d;
      end
      if (en2 & vld_q[1]) begin
        s2_q  <= s2_d;
        m_q   <= m_d;
        inx_q <= inx_d;
      end
      if (en3 & vld_q[2]) begin
        o_float_S   <= s_d;
        o_overflow  <= ovf_d;
        o_underflow <= unf_d;
        o_inexact   <= inx3_d;
        o_zero      <= zero_d;
        o_NaN       <= nan_d;
      end
    end
  end
endmodule

// File: tb/tb_fpu_mul_pipe.sv
// Directed bench for fpu_mul_pipe (binary32): hand-computed products, latency,
// backpressure stability/ordering and mid-flight reset.
module tb_fpu_mul_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic        o_ready, o_valid, o_overflow, o_underflow, o_inexact, o_zero, o_NaN;
  logic [31:0] o_float_S;
  logic [4:0]  flg;

  fpu_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_float_A(A), .i_float_B(B), .o_valid(o_valid), .i_ready(i_ready),
    .o_float_S(o_float_S), .o_overflow(o_overflow), .o_underflow(o_underflow),
    .o_inexact(o_inexact), .o_zero(o_zero), .o_NaN(o_NaN)
  );

  always #5 clk = ~clk;
  assign flg = {o_overflow, o_underflow, o_inexact, o_zero, o_NaN};

  // flags order: {overflow, underflow, inexact, zero, NaN}
  logic [31:0] va [12] = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000,
                           32'h7F800000, 32'hFF800000, 32'h3F800001, 32'h3F800003,
                           32'h80000000, 32'h7FC00001, 32'hC0000000, 32'h3FFFFFFF};
  logic [31:0] vb [12] = '{32'h40000000, 32'h3F800001, 32'h7F000000, 32'h3F000000,
                           32'h00000000, 32'h40000000, 32'h3FC00000, 32'h3FC00000,
                           32'h40000000, 32'h3F800000, 32'h40400000, 32'h3FFFFFFF};
  logic [31:0] vs [12] = '{32'h40400000, 32'h3F800002, 32'h7F800000, 32'h00000000,
                           32'h7FC00000, 32'hFF800000, 32'h3FC00002, 32'h3FC00004,
                           32'h80000000, 32'h7FC00000, 32'hC0C00000, 32'h407FFFFE};
  logic [4:0]  vf [12] = '{5'b00000, 5'b00100, 5'b10100, 5'b01110,
                           5'b00001, 5'b00000, 5'b00100, 5'b00100,
                           5'b00010, 5'b00001, 5'b00000, 5'b00100};

  int n_chk = 0, n_err = 0;
  int exp_q[$];
  int acc_n = 0, stall_at = -1, n_out = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: checks every transfer against the scoreboard and stall stability.
  logic        hold = 1'b0;
  logic [31:0] hold_s;
  logic [4:0]  hold_f;
  always @(negedge clk) begin
    int idx;
    #2;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_data", o_float_S, hold_s);
        chk("stall_flags", 32'(flg), 32'(hold_f));
      end
      hold = 1'b0;
      if (o_valid && !i_ready) begin
        hold = 1'b1; hold_s = o_float_S; hold_f = flg;
      end
      if (o_valid && i_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_out", 32'(o_valid), 32'd0);
        else begin
          idx = exp_q.pop_front();
          chk($sformatf("S[%0d]", idx), o_float_S, vs[idx]);
          chk($sformatf("flags[%0d]", idx), 32'(flg), 32'(vf[idx]));
        end
      end
    end
  end

  // Call at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int idx);
    bit done = 1'b0;
    i_valid = 1'b1; A = va[idx]; B = vb[idx];
    for (int t = 0; t < 60 && !done; t++) begin
      #1;
      if (o_ready) begin
        exp_q.push_back(idx); acc_n++; done = 1'b1;
      end else if (stall_at < 0) stall_at = acc_n;
      @(negedge clk);
    end
    if (!done) chk("send_timeout", 32'(o_ready), 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      @(negedge clk); #3;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic lat_test(input int idx);
    @(negedge clk);
    i_ready = 1'b1; i_valid = 1'b1; A = va[idx]; B = vb[idx];
    #1;
    chk("lat_ready", 32'(o_ready), 32'd1);
    exp_q.push_back(idx);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      i_valid = 1'b0;
      #1;
      chk($sformatf("lat_valid_c%0d", k), 32'(o_valid), 32'(k == 3));
    end
  endtask

  initial begin
    logic [31:0] pat;
    pat = 32'b1011_0010_1110_0101_0011_1001_0110_1101;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_S", o_float_S, 32'd0);
    chk("rst_flags", 32'(flg), 32'd0);

    lat_test(0);
    drain();

    // full-rate stream of every vector
    @(negedge clk);
    for (int i = 0; i < 12; i++) send(i);
    drain();

    // same stream under an irregular i_ready pattern
    @(negedge clk);
    fork
      begin for (int i = 0; i < 12; i++) send(i); end
      begin
        for (int c = 0; c < 32; c++) begin i_ready = pat[c]; @(negedge clk); end
        i_ready = 1'b1;
      end
    join
    drain();

    // backpressure: three ops fill the pipe, then o_ready must drop
    @(negedge clk);
    stall_at = -1; acc_n = 0; i_ready = 1'b0;
    fork
      begin for (int i = 0; i < 6; i++) send(i); end
      begin repeat (5) @(negedge clk); i_ready = 1'b1; end
    join
    drain();
    chk("bp_accepted_before_stall", 32'(stall_at), 32'd3);

    // reset with three ops in flight: none may emerge
    @(negedge clk);
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(i);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; i_ready = 1'b1; n_out = 0;
    repeat (6) @(negedge clk);
    #3;
    chk("rst_flush_outputs", 32'(n_out), 32'd0);
    lat_test(6);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fpu_mul_pipe.md
Name: fpu_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754 floating-point multiplier. It is the successor of the combinational 32-bit FPU multiplier.
- Generalised exponent and fraction widths. Default configuration is binary32.
- Adds round-to-nearest-even, real underflow detection, an inexact flag, canonical NaN output, and a valid/ready handshake with backpressure over a fixed 3-stage pipeline.
- Sits in the FPU datapath between operand issue and the FP writeback/result arbiter.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden 1 not included).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block can accept operands this cycle.
- i_float_A  in  EXP_W+MAN_W+1  operand A.
- i_float_B  in  EXP_W+MAN_W+1  operand B.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_float_S  out  EXP_W+MAN_W+1  product.
- o_overflow  out  1  finite operands gave a result too large to represent.
- o_underflow  out  1  nonzero result below the normal range, flushed to zero.
- o_inexact  out  1  result was rounded or flushed.
- o_zero  out  1  result is ±0.
- o_NaN  out  1  result is NaN.

Behaviour:
- Reset: all stage valid bits clear. o_valid=0, o_float_S=0, all flags 0, o_ready=1 in the cycle after reset. Reset mid-operation discards every in-flight operation; no result is emitted for them.
- Handshake:
  - An input transfer occurs when i_valid & o_ready.
  - An output transfer occurs when o_valid & i_ready.
  - o_valid and o_float_S/flags stay stable until the output transfer completes.
- Pipeline:
  - Stages S1, S2, S3; S3 drives the outputs.
  - Stage k advances when stage k+1 is empty or advancing.
  - o_ready = ~S1.valid | S1.advance.
  - Throughput is 1 op/cycle.
  - Latency is 3 cycles from the input transfer to o_valid when i_ready=1.
  - Results emerge in input order; there are no bubbles or duplicates under any i_ready pattern.
- S1 (unpack/multiply):
  - Classify each operand as zero (exp=0, subnormal fraction ignored, i.e. DAZ), inf, NaN or normal.
  - Sign = A.sign ^ B.sign.
  - Exponent sum E = eA + eB - bias, held as a signed EXP_W+2-bit value.
  - Register the full (MAN_W+1)x(MAN_W+1) product P, of width 2*MAN_W+2.
- S2 (normalise/round):
  - If P[msb]=1: mant = P[msb-1 -: MAN_W], E += 1. Otherwise mant = P[msb-2 -: MAN_W].
  - G = the next bit below mant; St = OR of all lower bits.
  - Round up iff G & (St | mant[0]).
  - If rounding carries out, mant = 0 and E += 1.
  - inexact_raw = G | St.
- S3 (special cases/pack), in priority order:
  - Either operand NaN, or inf×zero: output canonical qNaN (sign 0, exp all 1s, fraction MSB 1, rest 0). o_NaN=1, other flags 0.
  - Either operand inf: output ±inf, all flags 0.
  - Either operand zero: output ±0, o_zero=1.
  - E >= 2^EXP_W-1: output ±inf, o_overflow=1, o_inexact=1.
  - E <= 0: output ±0 (flush to zero), o_underflow=1, o_inexact=1, o_zero=1.
  - Otherwise: output {sign, E[EXP_W-1:0], mant}, o_inexact = inexact_raw.
- Flags are mutually consistent: o_NaN excludes all other flags, and o_overflow and o_underflow are never both 1.
- Simultaneous input and output transfers when the pipeline is full are legal and keep the pipe full.

Test Plan:
- 0x3FC00000 × 0x40000000 with i_ready=1: 0x40400000 appears exactly 3 cycles after the input transfer; all flags 0.
- 0x3F800001 × 0x3F800001: result 0x3F800002, o_inexact=1 (round-to-nearest-even, G=0, St=1 rounds down; covers the sticky path).
- 0x7F000000 × 0x7F000000: result 0x7F800000, o_overflow=1, o_inexact=1. 0x00800000 × 0x3F000000: result 0x00000000, o_underflow=1, o_zero=1.
- 0x7F800000 × 0x00000000: result 0x7FC00000, o_NaN=1. 0xFF800000 × 0x40000000: result 0xFF800000, no flags set.
- Backpressure: stream 6 ops with i_valid=1 while i_ready=0 for 5 cycles. o_ready must drop after 3 accepted ops; once i_ready=1, all 6 results arrive in order, with outputs held stable while stalled.
- Reset while 3 ops are in flight: no o_valid afterwards. A new op issued after reset returns its correct result with 3-cycle latency.
